bnn_conv_engine: RTL and testbench

- Parametrised, time-multiplexed successor to the combinational binary conv2 stage.
- Each accepted window of WINDOW_BITS binarised activations is XNORed against NUM_OUT_CH runtime-loadable weight vectors. The matches are popcounted and compared to per-channel programmable thresholds.
- LANES output channels are evaluated per cycle, trading latency for area.
- Sits between the line/window buffer and the pooling stage, with valid/ready handshakes on both sides.

---
 rtl/bnn_conv_engine.sv | 90 +++++++++
 tb/tb_bnn_conv_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bnn_conv_engine.sv
// bnn_conv_engine: time-multiplexed binary conv stage, XNOR-popcount-threshold over LANES channels per cycle
module bnn_conv_engine #(
  parameter int WINDOW_BITS = 72,
  parameter int NUM_OUT_CH = 16,
  parameter int LANES = 4,
  parameter int THRESH = 36,
  localparam int CW = $clog2(WINDOW_BITS + 1),
  localparam int CHW = $clog2(NUM_OUT_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WINDOW_BITS-1:0] in_window,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_OUT_CH-1:0]  out_data,
  input  logic                   cfg_we,
  input  logic [CHW-1:0]         cfg_ch,
  input  logic [WINDOW_BITS-1:0] cfg_weight,
  input  logic [CW-1:0]          cfg_thresh,
  output logic                   cfg_busy
);
  localparam int G = NUM_OUT_CH / LANES;
  localparam int GW = G > 1 ? $clog2(G) : 1;
  if (NUM_OUT_CH % LANES != 0) begin : g_bad_lanes
    $error("NUM_OUT_CH must be a multiple of LANES");
  end
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  state_t state;
  logic [GW-1:0] grp;
  logic [WINDOW_BITS-1:0] win;
  logic [WINDOW_BITS-1:0] weight [NUM_OUT_CH];
  logic [CW-1:0] thresh [NUM_OUT_CH];
  logic [LANES-1:0] lane_out;
  function automatic logic [CW-1:0] popcnt(input logic [WINDOW_BITS-1:0] v);
    popcnt = '0;
    for (int i = 0; i < WINDOW_BITS; i++) popcnt += CW'(v[i]);
  endfunction
  always_comb begin
    lane_out = '0;
    for (int l = 0; l < LANES; l++)
      lane_out[l] = popcnt(~(win ^ weight[CHW'(int'(grp) * LANES + l)])) > thresh[CHW'(int'(grp) * LANES + l)];
  end
  assign in_ready = (state == IDLE) && !cfg_we;
  assign cfg_busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grp <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      win <= '0;
      for (int c = 0; c < NUM_OUT_CH; c++) begin
        weight[c] <= '0;
        thresh[c] <= CW'(THRESH);
      end
    end else begin
      case (state)
        IDLE:
          if (cfg_we) begin
            for (int c = 0; c < NUM_OUT_CH; c++)
              if (cfg_ch == CHW'(c)) begin
                weight[c] <= cfg_weight;
                thresh[c] <= cfg_thresh;
              end
          end else if (in_valid) begin
            win <= in_window;
            out_data <= '0;
            grp <= '0;
            state <= CALC;
          end
        CALC: begin
          out_data[int'(grp) * LANES +: LANES] <= lane_out;
          grp <= grp + 1'b1;
          if (grp == GW'(G - 1)) begin
            out_valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD:
          if (out_ready) begin
            out_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bnn_conv_engine.sv
// tb_bnn_conv_engine: directed self-checking bench for bnn_conv_engine
module tb_bnn_conv_engine;
  localparam int WB = 72;
  localparam int NC = 16;
  localparam int CW = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic cfg_we = 1'b0;
  logic in_ready, out_valid, cfg_busy;
  logic [WB-1:0] in_window = '0;
  logic [WB-1:0] cfg_weight = '0;
  logic [NC-1:0] out_data;
  logic [3:0] cfg_ch = '0;
  logic [CW-1:0] cfg_thresh = '0;
  logic [WB-1:0] ones = '1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  bnn_conv_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_weight(cfg_weight), .cfg_thresh(cfg_thresh), .cfg_busy(cfg_busy)
  );
  task automatic cfg(input logic [3:0] ch, input logic [WB-1:0] w, input logic [CW-1:0] th);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_weight = w;
    cfg_thresh = th;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask
  task automatic run_frame(input logic [WB-1:0] w, output int lat, output logic quiet);
    int n;
    in_valid = 1'b1;
    in_window = w;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_window = ~w;
    lat = 0;
    quiet = 1'b1;
    while (!out_valid && lat < 20) begin
      if (in_ready !== 1'b0 || cfg_busy !== 1'b1) quiet = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL reset_cfg_busy got=%b exp=0", cfg_busy); end
    @(negedge clk);
  endtask
  task automatic test_default();
    int lat;
    logic quiet;
    run_frame('0, lat, quiet);
    checks++; if (lat !== 4) begin failures++; $display("FAIL default_latency got=%0d exp=4", lat); end
    checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL default_busy_during_calc got=%b exp=1", quiet); end
    checks++; if (out_data !== 16'hFFFF) begin failures++; $display("FAIL default_data got=%h exp=ffff", out_data); end
    consume();
  endtask
  task automatic test_threshold();
    int lat;
    logic quiet;
    cfg(4'd3, ones, 7'd36);
    run_frame({35'd0, {37{1'b1}}}, lat, quiet);
    checks++; if (out_data !== 16'h0008) begin failures++; $display("FAIL thresh_37 got=%h exp=0008", out_data); end
    consume();
    run_frame({36'd0, {36{1'b1}}}, lat, quiet);
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL thresh_36_boundary got=%h exp=0000", out_data); end
    consume();
  endtask
  task automatic test_backpressure();
    int lat;
    logic quiet;
    run_frame('0, lat, quiet);
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 16'hFFF7 || in_ready !== 1'b0) begin
        failures++; $display("FAIL hold_stable cyc=%0d got valid=%b data=%h rdy=%b exp 1/fff7/0", i, out_valid, out_data, in_ready);
      end
      @(negedge clk);
    end
    consume();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== 16'hFFF7) begin failures++; $display("FAIL release_data_kept got=%h exp=fff7", out_data); end
  endtask
  task automatic test_cfg_during_calc();
    int lat;
    logic quiet;
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_window = ones;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1;
    cfg_ch = 4'd0;
    cfg_weight = ones;
    cfg_thresh = 7'd0;
    #1;
    checks++; if (cfg_busy !== 1'b1) begin failures++; $display("FAIL calc_cfg_busy got=%b exp=1", cfg_busy); end
    @(negedge clk);
    cfg_we = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (out_data !== 16'h0008) begin failures++; $display("FAIL calc_frame_data got=%h exp=0008", out_data); end
    consume();
    run_frame(ones, lat, quiet);
    checks++; if (out_data !== 16'h0008) begin failures++; $display("FAIL dropped_write_data got=%h exp=0008", out_data); end
    consume();
  endtask
  task automatic test_cfg_priority();
    int lat;
    logic quiet;
    cfg_we = 1'b1;
    cfg_ch = 4'd5;
    cfg_weight = ones;
    cfg_thresh = 7'd0;
    in_valid = 1'b1;
    in_window = ones;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL prio_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL prio_not_accepted got=%b exp=0", cfg_busy); end
    run_frame(ones, lat, quiet);
    checks++; if (lat !== 4) begin failures++; $display("FAIL prio_latency got=%0d exp=4", lat); end
    checks++; if (out_data !== 16'h0028) begin failures++; $display("FAIL prio_data got=%h exp=0028", out_data); end
    consume();
  endtask
  task automatic test_reset_mid_calc();
    int lat;
    logic quiet;
    in_valid = 1'b1;
    in_window = '0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL midreset_out_data got=%h exp=0000", out_data); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || cfg_busy !== 1'b0) begin failures++; $display("FAIL midreset_idle got rdy=%b busy=%b exp 1/0", in_ready, cfg_busy); end
    run_frame('0, lat, quiet);
    checks++; if (out_data !== 16'hFFFF) begin failures++; $display("FAIL midreset_defaults got=%h exp=ffff", out_data); end
    consume();
    run_frame({35'd0, {37{1'b1}}}, lat, quiet);
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL midreset_thresh got=%h exp=0000", out_data); end
    consume();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_default();
    test_threshold();
    test_backpressure();
    test_cfg_during_calc();
    test_cfg_priority();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
